uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single UART transmitter between N byte-stream sources, such as the LPC frame dumper and status/debug emitters. It grants one source at a time for a whole packet, which ends on a byte flagged `last`. It drives the transmitter through the `uart_ready` / `uart_clock_enable` byte handshake. It sits between the sniffer's serializers and the UART TX core.

## Interface
Parameters:
- `N`, 2: number of sources (2..4).
- `IDLE_TIMEOUT`, 255: cycles a granted source may stall mid-packet before its grant is revoked (1..255).

Ports:
- `clock`, in, 1: sole clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `src_valid`, in, N: source i has a byte on its data lane.
- `src_data`, in, 8*N: lane i at bits [8i+7:8i]; held stable while valid until ack.
- `src_last`, in, N: byte on lane i is the final byte of its packet.
- `src_ack`, out, N: one-cycle pulse; byte on lane i has been taken.
- `grant`, out, N: one-hot owner of the transmitter; all zero when idle.
- `uart_ready`, in, 1: transmitter idle and able to accept a byte.
- `uart_data`, out, 8: byte presented to the transmitter.
- `uart_clock_enable`, out, 1: load strobe; held until `uart_ready` is seen low.
- `abort_count`, out, 8: saturating count of timed-out packets.

## Operation
- Reset values: `grant`=0, `src_ack`=0, `uart_data`=0x00, `uart_clock_enable`=0, `abort_count`=0, state IDLE, round-robin pointer such that source 0 has top priority, stall counter 0.
- States:
  - IDLE:
    - If any `src_valid` is set, pick the first set bit searching from pointer+1 (mod N).
    - Register the one-hot `grant` and go to HDR1 (macro set) or LOAD.
  - HDR1 / HDR2, macro only:
    - When `uart_ready`, drive `uart_data`=0xFF and `uart_clock_enable`=1.
    - Go to HDR1_W / HDR2_W.
  - HDR1_W / HDR2_W:
    - On `!uart_ready`, drop enable and advance to HDR2 / LOAD.
  - LOAD:
    - If `uart_ready` and `src_valid[g]`: `uart_data`←lane g, `src_ack[g]`=1 for one cycle, enable=1, capture `src_last[g]` as `is_last`, clear stall counter, go to SEND_W.
    - If `uart_ready` and not valid: increment stall counter.
  - SEND_W:
    - On `!uart_ready`, enable←0.
    - If `is_last`: pointer←g, `grant`←0, go to IDLE.
    - Otherwise go to LOAD.
- Timeout:
  - Applies in LOAD when the stall counter reaches `IDLE_TIMEOUT`.
  - `grant`←0, pointer←g, `abort_count`+1 (saturates at 255), go to IDLE.
  - No trailer byte is sent.
- Invariants:
  - `src_ack` is only ever asserted on the granted lane.
  - Valid bits on non-granted lanes are ignored until the packet ends.
  - `uart_data` changes only in the cycle `uart_clock_enable` rises.
- A source that drops `src_valid` before ack loses nothing; the byte is not consumed.

## Timing
- Grant latency: `src_valid` seen in IDLE at cycle t gives `grant` high at t+1.
- First-byte latency, macro off: earliest `src_ack` and enable at t+2 if `uart_ready` is high.
- First-byte latency, macro on: header bytes precede the first data byte.
- Per byte:
  - Enable rises, then stays high until the first cycle `uart_ready`=0 is sampled; it falls the next edge.
  - The next byte loads no earlier than the first cycle `uart_ready` returns high in LOAD.
- Re-arbitration: IDLE is entered the cycle after the last byte's handshake completes; a new grant follows one cycle later. Minimum gap between packets is 1 idle cycle.
- Simultaneous requests in IDLE: round-robin; the just-served source has lowest priority.
- Reset asserted mid-packet:
  - All outputs return to reset values on the next edge.
  - The in-flight byte is abandoned; the UART core is expected to be reset by the same `reset`.
- `uart_ready` low while in LOAD/HDR: wait indefinitely; the stall counter does not count.

## Configuration
- `UART_ARB_SYNC_HDR_EN` defined: each granted packet is prefixed by two 0xFF sync bytes (states HDR1..HDR2_W). These bytes are not acknowledged to any source.
- Not defined: HDR states are absent; IDLE goes directly to LOAD; the stream contains only source bytes.

## Test plan
1. N=2, macro off, src0 sends packet {0x11,0x22,last 0x33} with `uart_ready` modelled (ready drops 2 cycles after enable, returns 10 cycles later) -> UART sees 0x11,0x22,0x33; three `src_ack[0]` pulses; `grant` returns to 0.
2. Both sources valid in the same IDLE cycle after reset -> src0 served first, then src1; repeat -> src0 before src1 again; bytes never interleave within a packet.
3. Macro on, src1 sends single byte 0xA5 last -> UART sees 0xFF,0xFF,0xA5; exactly one `src_ack[1]`.
4. src0 sends 0x01 (not last) then drops valid; `IDLE_TIMEOUT`=4 -> grant revoked after 4 ready-and-idle cycles; `abort_count`=1; pending src1 then granted.
5. `reset` pulsed while `uart_clock_enable`=1 mid-packet -> next edge: enable=0, `grant`=0, `uart_data`=0x00, `abort_count`=0; fresh packet from src1 transmits correctly.
6. `uart_ready` held low 50 cycles during LOAD -> no ack, no timeout; byte loads in the first cycle ready returns high.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Packet-atomic round-robin arbiter sharing one UART transmitter between N
// byte-stream sources. A source keeps the grant until it delivers a byte
// flagged last, or until it stalls for IDLE_TIMEOUT ready cycles mid-packet.
// Bytes are handed to the transmitter with a load strobe that is held until
// the transmitter reports busy (uart_ready low).
//
// Optional feature macro: UART_ARB_SYNC_HDR_EN
//   defined   : every granted packet is prefixed with two 0xFF sync bytes
//               that are not acknowledged to any source.
//   undefined : the stream carries only source bytes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no owner; round-robin pick among valid sources
// ST_HDR1   | (macro) wait for ready, load first 0xFF sync byte
// ST_HDR1_W | (macro) hold strobe until transmitter goes busy
// ST_HDR2   | (macro) wait for ready, load second 0xFF sync byte
// ST_HDR2_W | (macro) hold strobe until transmitter goes busy
// ST_LOAD   | wait for ready and a byte from the owner; count stalls
// ST_SEND_W | hold strobe until busy; then next byte or release grant

module uart_tx_arbiter #(
  parameter int N            = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   src_valid,
  input  logic [8*N-1:0] src_data,
  input  logic [N-1:0]   src_last,
  output logic [N-1:0]   src_ack,
  output logic [N-1:0]   grant,
  input  logic           uart_ready,
  output logic [7:0]     uart_data,
  output logic           uart_clock_enable,
  output logic [7:0]     abort_count
);

  localparam int         PW      = $clog2(N);
  localparam logic [7:0] TIMEOUT = 8'(IDLE_TIMEOUT);
`ifdef UART_ARB_SYNC_HDR_EN
  localparam logic [7:0] SYNC_BYTE = 8'hFF;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND_W = 3'd2
`ifdef UART_ARB_SYNC_HDR_EN
    ,
    ST_HDR1   = 3'd3,
    ST_HDR1_W = 3'd4,
    ST_HDR2   = 3'd5,
    ST_HDR2_W = 3'd6
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] gidx_q,  gidx_d;
  logic [PW-1:0] ptr_q,   ptr_d;
  logic [N-1:0]  ack_q,   ack_d;
  logic [7:0]    data_q,  data_d;
  logic          en_q,    en_d;
  logic [7:0]    abort_q, abort_d;
  logic [7:0]    stall_q, stall_d;
  logic          last_q,  last_d;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] cand;

  logic          cur_valid;
  logic          cur_last;
  logic [7:0]    cur_data;

  // Round-robin search starting one past the last served source.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
      if (!pick_found && src_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the owner's lane; constant indices keep the mux width-clean.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (gidx_q == PW'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[8*i +: 8];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    data_d  = data_q;
    en_d    = en_q;
    abort_d = abort_q;
    stall_d = stall_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          stall_d           = 8'd0;
`ifdef UART_ARB_SYNC_HDR_EN
          state_d           = ST_HDR1;
`else
          state_d           = ST_LOAD;
`endif
        end
      end

`ifdef UART_ARB_SYNC_HDR_EN
      ST_HDR1: begin
        if (uart_ready) begin
          data_d  = SYNC_BYTE;
          en_d    = 1'b1;
          state_d = ST_HDR1_W;
        end
      end

      ST_HDR1_W: begin
        if (!uart_ready) begin
          en_d    = 1'b0;
          state_d = ST_HDR2;
        end
      end

      ST_HDR2: begin
        if (uart_ready) begin
          data_d  = SYNC_BYTE;
          en_d    = 1'b1;
          state_d = ST_HDR2_W;
        end
      end

      ST_HDR2_W: begin
        if (!uart_ready) begin
          en_d    = 1'b0;
          state_d = ST_LOAD;
        end
      end
`endif

      ST_LOAD: begin
        // A busy transmitter is not the source's fault, so only ready
        // cycles without a byte count towards the stall timeout.
        if (uart_ready) begin
          if (cur_valid) begin
            data_d        = cur_data;
            ack_d[gidx_q] = 1'b1;
            en_d          = 1'b1;
            last_d        = cur_last;
            stall_d       = 8'd0;
            state_d       = ST_SEND_W;
          end else if (stall_q == TIMEOUT - 8'd1) begin
            grant_d = '0;
            ptr_d   = gidx_q;
            abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
            stall_d = 8'd0;
            state_d = ST_IDLE;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end

      ST_SEND_W: begin
        if (!uart_ready) begin
          en_d = 1'b0;
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves source 0 with top priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PW'(N - 1);
      ack_q   <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      abort_q <= 8'h00;
      stall_q <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      en_q    <= en_d;
      abort_q <= abort_d;
      stall_q <= stall_d;
      last_q  <= last_d;
    end
  end

  assign grant             = grant_q;
  assign src_ack           = ack_q;
  assign uart_data         = data_q;
  assign uart_clock_enable = en_q;
  assign abort_count       = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=2, IDLE_TIMEOUT=4).
// Expected byte streams include the two 0xFF sync bytes when the bench is
// built with UART_ARB_SYNC_HDR_EN, matching the design build.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int TMO = 4;
`ifdef UART_ARB_SYNC_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [N-1:0]  src_valid;
  logic [8*N-1:0] src_data;
  logic [N-1:0]  src_last;
  logic [N-1:0]  src_ack;
  logic [N-1:0]  grant;
  logic          uart_ready;
  logic [7:0]    uart_data;
  logic          uart_clock_enable;
  logic [7:0]    abort_count;

  uart_tx_arbiter #(.N(N), .IDLE_TIMEOUT(TMO)) dut (
    .clock             (clock),
    .reset             (reset),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_last          (src_last),
    .src_ack           (src_ack),
    .grant             (grant),
    .uart_ready        (uart_ready),
    .uart_data         (uart_data),
    .uart_clock_enable (uart_clock_enable),
    .abort_count       (abort_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // source byte queues {last, data}; written by the test, read by the driver
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int skip0, skip1;   // test: flush point
  int rd0, rd1;       // driver: read pointer

  // transmitter model state (written only by the model process)
  logic       m_ready;
  int         m_st, m_cnt;
  logic       prev_en;
  logic [7:0] prev_data;
  logic [7:0] cap_q[$];
  int ack_cnt0, ack_cnt1, ack_viol, data_viol, stall_cnt;

  // test-owned
  bit         hold_low;
  logic [7:0] exp_q[$];
  int         cap_rd;
  int         n_checks, n_errors;

  assign uart_ready = m_ready && !hold_low;

  // source driver: advance a lane on ack, present the head byte
  initial begin
    rd0 = 0; rd1 = 0;
    src_valid = '0; src_data = '0; src_last = '0;
    forever begin
      @(posedge clock); #1;
      if (src_ack[0] && rd0 < q0.size()) rd0++;
      if (src_ack[1] && rd1 < q1.size()) rd1++;
      if (rd0 < skip0) rd0 = skip0;
      if (rd1 < skip1) rd1 = skip1;
      if (rd0 < q0.size()) begin
        src_valid[0] = 1'b1; src_data[7:0] = q0[rd0][7:0]; src_last[0] = q0[rd0][8];
      end else begin
        src_valid[0] = 1'b0; src_data[7:0] = 8'h00; src_last[0] = 1'b0;
      end
      if (rd1 < q1.size()) begin
        src_valid[1] = 1'b1; src_data[15:8] = q1[rd1][7:0]; src_last[1] = q1[rd1][8];
      end else begin
        src_valid[1] = 1'b0; src_data[15:8] = 8'h00; src_last[1] = 1'b0;
      end
    end
  end

  // transmitter model and monitors: ready drops 2 cycles after the strobe
  // rises and returns 10 cycles later
  initial begin
    m_ready = 1'b1; m_st = 0; m_cnt = 0; prev_en = 1'b0; prev_data = 8'h00;
    ack_cnt0 = 0; ack_cnt1 = 0; ack_viol = 0; data_viol = 0; stall_cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_ready = 1'b1; m_st = 0; m_cnt = 0;
      end else begin
        if (uart_clock_enable && !prev_en) cap_q.push_back(uart_data);
        if (uart_data != prev_data && !(uart_clock_enable && !prev_en)) data_viol++;
        if ((src_ack & ~grant) != '0) ack_viol++;
        if (src_ack[0]) ack_cnt0++;
        if (src_ack[1]) ack_cnt1++;
        case (m_st)
          0: if (uart_clock_enable && !prev_en) begin m_st = 1; m_cnt = 1; end
          1: begin
            m_cnt++;
            if (m_cnt >= 2) begin m_ready = 1'b0; m_st = 2; m_cnt = 0; end
          end
          default: begin
            m_cnt++;
            if (m_cnt >= 10) begin m_ready = 1'b1; m_st = 0; m_cnt = 0; end
          end
        endcase
        if (grant == 2'b01 && !uart_clock_enable && m_ready && !hold_low && !src_valid[0])
          stall_cnt++;
      end
      prev_en   = uart_clock_enable;
      prev_data = uart_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_hdr();
`ifdef UART_ARB_SYNC_HDR_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
`endif
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b, input logic last);
    if (lane == 0) q0.push_back({last, b});
    else           q1.push_back({last, b});
    exp_q.push_back(b);
  endtask

  task automatic wait_valid(input string tag, input logic [1:0] pattern);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (src_valid == pattern) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (grant == '0 && !uart_clock_enable && uart_ready &&
          rd0 >= q0.size() && rd1 >= q1.size() &&
          (cap_q.size() - cap_rd) >= exp_q.size())
        done = 1'b1;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, cap_q.size() - cap_rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (cap_rd + i < cap_q.size())
        check({tag, "_byte"}, cap_q[cap_rd + i], exp_q[i]);
    cap_rd = cap_q.size();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    skip0 = q0.size();
    skip1 = q1.size();
    reset = 1'b0;
  endtask

  initial begin
    int a0, a1, s0;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; hold_low = 1'b0; skip0 = 0; skip1 = 0; cap_rd = 0;
    repeat (3) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_ack", src_ack, 0);
    check("rst_data", uart_data, 8'h00);
    check("rst_en", uart_clock_enable, 0);
    check("rst_abort", abort_count, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: single packet from src0, latency and byte order
    a0 = ack_cnt0;
    push_hdr();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    wait_valid("t1", 2'b01);
    @(negedge clock);
    check("t1_grant_latency", grant, 2'b01);
    @(negedge clock);
    check("t1_first_en", uart_clock_enable, 1);
    check("t1_first_ack", src_ack, HDR_ON ? 2'b00 : 2'b01);
    check("t1_first_data", uart_data, HDR_ON ? 8'hFF : 8'h11);
    wait_idle("t1", 400);
    check_stream("t1");
    check("t1_acks", ack_cnt0 - a0, 3);
    check("t1_grant_end", grant, 0);

    // 2: simultaneous requests after reset, twice
    do_reset();
    @(negedge clock);
    for (int r = 0; r < 2; r++) begin
      a0 = ack_cnt0; a1 = ack_cnt1;
      push_hdr();
      push_byte(0, 8'hA0 + 8'(2*r), 1'b0);
      push_byte(0, 8'hA1 + 8'(2*r), 1'b1);
      push_hdr();
      push_byte(1, 8'hB0 + 8'(2*r), 1'b0);
      push_byte(1, 8'hB1 + 8'(2*r), 1'b1);
      wait_valid("t2", 2'b11);
      @(negedge clock);
      check("t2_first_grant", grant, 2'b01);
      wait_idle("t2", 600);
      check_stream("t2");
      check("t2_acks0", ack_cnt0 - a0, 2);
      check("t2_acks1", ack_cnt1 - a1, 2);
    end

    // 3: single-byte packet from src1
    a0 = ack_cnt0; a1 = ack_cnt1;
    push_hdr();
    push_byte(1, 8'hA5, 1'b1);
    wait_idle("t3", 300);
    check_stream("t3");
    check("t3_acks1", ack_cnt1 - a1, 1);
    check("t3_acks0", ack_cnt0 - a0, 0);

    // 4: src0 stalls mid-packet, times out, pending src1 then served
    a0 = ack_cnt0; a1 = ack_cnt1; s0 = stall_cnt;
    push_hdr();
    push_byte(0, 8'h01, 1'b0);
    push_hdr();
    push_byte(1, 8'h55, 1'b1);
    wait_idle("t4", 600);
    check_stream("t4");
    check("t4_stall_cycles", stall_cnt - s0, TMO);
    check("t4_abort_count", abort_count, 1);
    check("t4_acks0", ack_cnt0 - a0, 1);
    check("t4_acks1", ack_cnt1 - a1, 1);

    // 5: reset while the strobe is high mid-packet
    push_hdr();
    push_byte(0, 8'hC0, 1'b0);
    q0.push_back({1'b1, 8'hC1});
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge clock);
        if (uart_clock_enable && uart_data == 8'hC0) hit = 1'b1;
      end
      check("t5_strobe_seen", hit, 1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_en", uart_clock_enable, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_data", uart_data, 8'h00);
    check("t5_rst_abort", abort_count, 0);
    check("t5_rst_ack", src_ack, 0);
    skip0 = q0.size();
    skip1 = q1.size();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_stream("t5_pre");
    a1 = ack_cnt1;
    push_hdr();
    push_byte(1, 8'h5A, 1'b0);
    push_byte(1, 8'h5B, 1'b1);
    wait_idle("t5", 400);
    check_stream("t5");
    check("t5_acks1", ack_cnt1 - a1, 2);

    // 6: transmitter busy for 50 cycles while a byte waits
    hold_low = 1'b1;
    a0 = ack_cnt0;
    push_hdr();
    push_byte(0, 8'hD0, 1'b0);
    push_byte(0, 8'hD1, 1'b1);
    repeat (50) @(negedge clock);
    check("t6_no_ack", ack_cnt0 - a0, 0);
    check("t6_grant_held", grant, 2'b01);
    check("t6_en_low", uart_clock_enable, 0);
    hold_low = 1'b0;
    @(negedge clock);
    check("t6_load_en", uart_clock_enable, 1);
    check("t6_load_ack", src_ack, HDR_ON ? 2'b00 : 2'b01);
    check("t6_load_data", uart_data, HDR_ON ? 8'hFF : 8'hD0);
    wait_idle("t6", 400);
    check_stream("t6");
    check("t6_acks0", ack_cnt0 - a0, 2);
    check("t6_no_abort", abort_count, 0);

    check("inv_ack_on_grant", ack_viol, 0);
    check("inv_data_on_strobe", data_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
